ram_test_sequencer: RTL and testbench

//  Self-test controller for the single-port on-chip RAM under test in the JTAG RAM test system.

---
 rtl/ram_test_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_ram_test_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ram_test_sequencer
//  Description : March self-test controller for a single-port synchronous RAM.
//                Phases: ascending write P, ascending read/compare P,
//                descending write ~P, descending read/compare ~P, where
//                P(a) = seed + a. Reports pass/fail, a saturating mismatch
//                count and the first failing address.
//                Optional build macro: RAM_TEST_STOP_ON_ERR_EN (end the run on
//                the first mismatch).
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_test_sequencer #(
  parameter int DW        = 32,
  parameter int AW        = 7,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DW-1:0]        seed,
  input  logic [AW-1:0]        addr_first,
  input  logic [AW-1:0]        addr_last,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [AW-1:0]        first_err_addr,
  output logic                 ram_we,
  output logic [AW-1:0]        ram_addr,
  output logic [DW-1:0]        ram_wdata,
  input  logic [DW-1:0]        ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ASC  = 3'd1,
    S_RD_ASC  = 3'd2,
    S_DRAIN_A = 3'd3,
    S_WR_DSC  = 3'd4,
    S_RD_DSC  = 3'd5,
    S_DRAIN_D = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam logic [ERR_CNT_W-1:0] c_err_max = {ERR_CNT_W{1'b1}};

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [DW-1:0]          r_seed;
  logic [AW-1:0]          r_first;
  logic [AW-1:0]          r_last;
  logic [AW-1:0]          r_addr;

  logic                   r_cmp_valid;
  logic                   r_cmp_inv;
  logic [AW-1:0]          r_cmp_addr;

  logic [ERR_CNT_W-1:0]   r_err_cnt;
  logic [AW-1:0]          r_first_err;
  logic                   r_pass;

  logic                   w_start_go;
  logic                   w_rd_issue;
  logic                   w_mismatch;
  logic                   w_enter_done;
  logic [DW-1:0]          w_wr_pat;
  logic [DW-1:0]          w_cmp_pat;
  logic [DW-1:0]          w_cmp_exp;
  logic [ERR_CNT_W-1:0]   w_err_nxt;

  // A run is accepted only from IDLE, and abort wins over start.
  assign w_start_go = (r_state == S_IDLE) && start && !abort;
  assign w_rd_issue = (r_state == S_RD_ASC) || (r_state == S_RD_DSC);

  // Pattern for the address currently driven and for the address read last cycle.
  assign w_wr_pat   = r_seed + DW'(r_addr);
  assign w_cmp_pat  = r_seed + DW'(r_cmp_addr);
  assign w_cmp_exp  = r_cmp_inv ? ~w_cmp_pat : w_cmp_pat;

  // A compare still in flight when abort is taken never reaches the counters.
  assign w_mismatch = r_cmp_valid && !abort && (ram_rdata != w_cmp_exp);
  assign w_err_nxt  = (w_mismatch && (r_err_cnt != c_err_max)) ? r_err_cnt + 1'b1 : r_err_cnt;

  // Completion of an active run (the invalid-window shortcut leaves IDLE directly).
  assign w_enter_done = (w_state_nxt == S_DONE) && (r_state != S_IDLE) && (r_state != S_DONE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and RAM/handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    ram_we      = 1'b0;
    ram_wdata   = '0;

    case (r_state)
      S_IDLE: begin
        if (w_start_go) begin
          w_state_nxt = (addr_last < addr_first) ? S_DONE : S_WR_ASC;
        end
      end
      S_WR_ASC: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_wdata = w_wr_pat;
        if (r_addr == r_last) w_state_nxt = S_RD_ASC;
      end
      S_RD_ASC: begin
        busy = 1'b1;
        if (r_addr == r_last) w_state_nxt = S_DRAIN_A;
      end
      S_DRAIN_A: begin
        busy        = 1'b1;
        w_state_nxt = S_WR_DSC;
      end
      S_WR_DSC: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_wdata = ~w_wr_pat;
        if (r_addr == r_first) w_state_nxt = S_RD_DSC;
      end
      S_RD_DSC: begin
        busy = 1'b1;
        if (r_addr == r_first) w_state_nxt = S_DRAIN_D;
      end
      S_DRAIN_D: begin
        busy        = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

`ifdef RAM_TEST_STOP_ON_ERR_EN
    // The first mismatch ends the run; remaining phases are skipped.
    if (w_mismatch) w_state_nxt = S_DONE;
`endif

    if (abort && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
  end

  // Run parameters and the march address counter. The counter stops on the
  // window end rather than counting, so a full 0..2^AW-1 window cannot wrap early.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seed  <= '0;
      r_first <= '0;
      r_last  <= '0;
      r_addr  <= '0;
    end else if (w_start_go) begin
      r_seed  <= seed;
      r_first <= addr_first;
      r_last  <= addr_last;
      r_addr  <= addr_first;
    end else begin
      case (r_state)
        S_WR_ASC: begin
          if (r_addr == r_last) r_addr <= r_first;
          else                  r_addr <= r_addr + 1'b1;
        end
        S_RD_ASC: begin
          if (r_addr != r_last) r_addr <= r_addr + 1'b1;
        end
        S_DRAIN_A: begin
          r_addr <= r_last;
        end
        S_WR_DSC: begin
          if (r_addr == r_first) r_addr <= r_last;
          else                   r_addr <= r_addr - 1'b1;
        end
        S_RD_DSC: begin
          if (r_addr != r_first) r_addr <= r_addr - 1'b1;
        end
        default: begin
          r_addr <= r_addr;
        end
      endcase
    end
  end

  // Compare pipeline: remembers what was read so it can be checked when data returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmp_valid <= 1'b0;
      r_cmp_inv   <= 1'b0;
      r_cmp_addr  <= '0;
    end else begin
      r_cmp_valid <= w_rd_issue && !abort && (w_state_nxt != S_DONE);
      r_cmp_inv   <= (r_state == S_RD_DSC);
      r_cmp_addr  <= r_addr;
    end
  end

  // Result bookkeeping: error count, first failing address and pass flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_pass      <= 1'b0;
    end else if (w_start_go) begin
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_pass      <= 1'b0;
    end else if (abort && (r_state != S_IDLE)) begin
      r_pass      <= 1'b0;
    end else begin
      r_err_cnt <= w_err_nxt;
      if (w_mismatch && (r_err_cnt == '0)) begin
        r_first_err <= r_cmp_addr;
      end
      if (w_enter_done) begin
        r_pass <= (w_err_nxt == '0);
      end
    end
  end

  assign ram_addr       = r_addr;
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err;
  assign pass           = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_ram_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_test_sequencer
//  Description : Self-checking bench for ram_test_sequencer. A behavioural
//                RAM with an optional stuck-at-0 bit mask sits on the RAM port;
//                expected results come from a march-level model of each run.
//                A second instance with a 2-bit error counter is fed inverted
//                read data to exercise counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_test_sequencer;
  localparam int DW = 32;
  localparam int AW = 7;
  localparam int EW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] seed = '0;
  logic [AW-1:0] addr_first = '0;
  logic [AW-1:0] addr_last = '0;
  wire           busy, done, pass, ram_we;
  wire  [EW-1:0] err_cnt;
  wire  [AW-1:0] first_err_addr, ram_addr;
  wire  [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  wire           s_busy, s_done, s_pass, s_ram_we;
  wire  [1:0]    s_err_cnt;
  wire  [AW-1:0] s_first_err_addr, s_ram_addr;
  wire  [DW-1:0] s_ram_wdata;
  wire  [DW-1:0] s_ram_rdata = ~ram_rdata;

  logic [DW-1:0] ram_mask = '0;
  logic [DW-1:0] mem [2**AW];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_test_sequencer #(.DW(DW), .AW(AW), .ERR_CNT_W(EW)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .seed(seed),
    .addr_first(addr_first), .addr_last(addr_last), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  ram_test_sequencer #(.DW(DW), .AW(AW), .ERR_CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .seed(seed),
    .addr_first(addr_first), .addr_last(addr_last), .busy(s_busy), .done(s_done),
    .pass(s_pass), .err_cnt(s_err_cnt), .first_err_addr(s_first_err_addr),
    .ram_we(s_ram_we), .ram_addr(s_ram_addr), .ram_wdata(s_ram_wdata), .ram_rdata(s_ram_rdata)
  );

  // Synchronous RAM; masked bits are stuck at 0 in the array.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata & ~ram_mask;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // March-level model: every word is written then read back, so a word fails
  // in a phase exactly when its pattern has a 1 in a stuck-at-0 bit.
  task automatic model_run(input logic [DW-1:0] s, input logic [AW-1:0] f, input logic [AW-1:0] l,
                           input logic [DW-1:0] m, output int done_cyc, output int err,
                           output int ferr, output bit pass_e, output int n);
    logic [DW-1:0] e;
    int a, issue;
    err = 0; ferr = 0;
    if (l < f) begin
      n = 0; done_cyc = 1; pass_e = 1'b0;
      return;
    end
    n = int'(l) - int'(f) + 1;
    done_cyc = 4 * n + 3;
    for (int k = 0; k < 2 * n; k++) begin
      if (k < n) begin
        a = int'(f) + k; e = s + DW'(a); issue = n + 1 + k;
      end else begin
        a = int'(l) - (k - n); e = ~(s + DW'(a)); issue = 3 * n + 2 + (k - n);
      end
      if ((e & ~m) != e) begin
        if (err == 0) ferr = a;
        err++;
`ifdef RAM_TEST_STOP_ON_ERR_EN
        done_cyc = issue + 2;
        break;
`endif
      end
    end
    pass_e = (err == 0);
  endtask

  // One run from start (cycle 0) to done, checking the RAM port and status each cycle.
  task automatic run(input logic [DW-1:0] s, input logic [AW-1:0] f, input logic [AW-1:0] l,
                     input logic [DW-1:0] m, input int abort_at);
    int dc, err, ferr, n, a, sat_e;
    bit pe, we_e, seen_done;
    logic [DW-1:0] wd_e;
    model_run(s, f, l, m, dc, err, ferr, pe, n);
    ram_mask = m;
    seed = s; addr_first = f; addr_last = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= dc; c++) begin
      if (abort_at != 0 && c == abort_at + 1) begin
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_we", ram_we, 0);
        check_val("abort_pass", pass, 0);
        seen_done = 1'b0;
        repeat (4 * n + 8) begin
          @(posedge clk); #1;
          if (done) seen_done = 1'b1;
        end
        check_val("abort_no_done", seen_done, 0);
        return;
      end
      we_e = (n > 0) && (c < dc) && ((c <= n) || (c >= 2 * n + 2 && c <= 3 * n + 1));
      check_val("ram_we", ram_we, we_e);
      if (we_e) begin
        if (c <= n) begin
          a = int'(f) + c - 1; wd_e = s + DW'(a);
        end else begin
          a = int'(l) - (c - (2 * n + 2)); wd_e = ~(s + DW'(a));
        end
        check_val("ram_addr", ram_addr, 64'(a));
        check_val("ram_wdata", ram_wdata, wd_e);
      end
      check_val("busy", busy, c < dc);
      check_val("done", done, c == dc);
      if (c == dc) begin
        check_val("pass", pass, pe);
        check_val("err_cnt", err_cnt, 64'(err));
        check_val("first_err_addr", first_err_addr, 64'(ferr));
        if (m == '0 && n > 0) begin
`ifdef RAM_TEST_STOP_ON_ERR_EN
          sat_e = 1;
`else
          sat_e = (2 * n > 3) ? 3 : 2 * n;
`endif
          check_val("sat_err_cnt", s_err_cnt, 64'(sat_e));
          check_val("sat_pass", s_pass, 0);
        end
      end
      if (c == abort_at) abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end
    check_val("post_busy", busy, 0);
    check_val("post_done", done, 0);
    check_val("post_pass_held", pass, pe);
  endtask

  initial begin
    logic [AW-1:0] f, l;
    logic [DW-1:0] m;
    int ab, len;
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;

    // Reset state
    #2;
    check_val("rst_we", ram_we, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_pass", pass, 0);
    check_val("rst_err", err_cnt, 0);
    check_val("rst_ferr", first_err_addr, 0);
    check_val("rst_addr", ram_addr, 0);
    check_val("rst_wdata", ram_wdata, 0);
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;

    run(32'h1000_0000, 7'd8, 7'd11, '0, 0);     // ideal RAM, done at cycle 19
    run(32'h0, 7'd0, 7'd3, 32'h1, 0);           // bit0 stuck-at-0
    run(32'h0, 7'd5, 7'd2, '0, 0);              // invalid window
    run(32'hCAFE_0000, 7'd0, 7'd15, '0, 6);     // abort at cycle 6
    run(32'hCAFE_0000, 7'd0, 7'd15, '0, 0);     // restart, done at cycle 67
    run(32'h1234_5678, 7'd40, 7'd40, '0, 0);    // single word
    run($urandom, 7'd0, 7'd127, '0, 0);         // full window
    run(32'h0, 7'd0, 7'd7, 32'h2, 0);           // a=2 is the first failure

    // Randomized runs
    for (int i = 0; i < 12; i++) begin
      f = 7'($urandom_range(0, 127));
      if (f > 0 && $urandom_range(0, 5) == 0) begin
        l = 7'($urandom_range(0, int'(f) - 1));
      end else begin
        len = $urandom_range(0, 24);
        l = (int'(f) + len > 127) ? 7'd127 : 7'(int'(f) + len);
      end
      m  = ($urandom_range(0, 2) == 0) ? (32'h1 << $urandom_range(0, 31)) : '0;
      ab = ($urandom_range(0, 4) == 0 && l >= f) ? $urandom_range(1, 4 * (int'(l) - int'(f) + 1)) : 0;
      run($urandom, f, l, m, ab);
    end

    // Asynchronous reset in the middle of WR_DSC
    ram_mask = 32'h1; seed = '0; addr_first = 7'd0; addr_last = 7'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end   // cycle 11
    check_val("mid_we", ram_we, 1);
    check_val("mid_err", err_cnt, 2);
    check_val("mid_ferr", first_err_addr, 1);
    #2 reset = 1'b1;
    #1;
    check_val("arst_we", ram_we, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_done", done, 0);
    check_val("arst_pass", pass, 0);
    check_val("arst_err", err_cnt, 0);
    check_val("arst_ferr", first_err_addr, 0);
    check_val("arst_addr", ram_addr, 0);
    check_val("arst_wdata", ram_wdata, 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    run(32'h5A5A_0000, 7'd100, 7'd103, '0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
